clk_divider_prog: RTL
=====================

# clk_divider_prog

Runtime-programmable integer clock divider that generates the divided clock and a matching one-cycle enable pulse for the fixed-ratio divider chain and its consumers. Replaces hard-wired divide-by-N stages wherever the ratio must change in the field. Ratio changes and start/stop requests take effect only at a period boundary, so `clk_out` never produces a runt pulse. It is fully synchronous to `clk`: every output is registered and there is no negedge logic.

## Interface
- `DIV_W`, 8: width of the ratio field.
- `DEFAULT_DIV`, 6: active ratio after reset. Must be ≥ 2.
- `clk`  in  1  input clock; all logic is on the posedge.
- `reset`  in  1  reset, synchronous and active-low.
- `en`  in  1  run request, level-sensitive.
- `div_val`  in  DIV_W  requested ratio N, sampled when `div_load`=1.
- `div_load`  in  1  one-cycle request to load `div_val` into the shadow register.
- `div_ack`  out  1  one-cycle pulse in the cycle the new ratio becomes active.
- `clk_out`  out  1  divided clock.
- `clk_en`  out  1  one-cycle pulse in the first cycle of every `clk_out` period, coincident with the rising edge of `clk_out`.
- `busy`  out  1  high while a loaded ratio is pending and not yet active.

## Operation
- State machine has three states: STOPPED, RUNNING, STOPPING.
  - STOPPED → RUNNING when `en`=1.
  - RUNNING → STOPPING when `en`=0 mid-period.
  - STOPPING → RUNNING when `en` returns to 1 before the boundary.
  - STOPPING → STOPPED at the period boundary.
  - RUNNING → STOPPED directly when `en`=0 in the boundary cycle.
- The period counter `cnt` runs 0..N−1 while running.
  - `clk_out`=1 for `cnt` < ceil(N/2), 0 otherwise. Odd N is therefore high-biased: N=5 gives 3 cycles high, 2 low.
  - `cnt`=0 is the first cycle of a period; `cnt`=N−1 is the boundary cycle.
- Ratio clamp: any `div_val` < 2 (0 or 1) is treated as 2, both when loaded and when applied. No error flag.
- Shadow register:
  - `div_load`=1 captures the clamped `div_val` into the shadow and sets the pending flag (`busy`=1).
  - A second `div_load` while pending overwrites the shadow. Only the last value is applied and only one `div_ack` is issued.
- Applying a pending ratio:
  - In STOPPED: the ratio is applied in the cycle after `div_load`.
  - Running: the ratio is applied at the boundary. The next period (`cnt`=0) uses the new N, `div_ack`=1 and `clk_en`=1 in that same cycle, and `busy` clears.
- Simultaneous `div_load` and boundary: the value loaded in the boundary cycle is not applied at that boundary. It waits for the following boundary.
- Stop behaviour:
  - While stopped, `clk_out`=0 and `cnt`=0.
  - A stop always completes the current period, including the low phase.
- Reset mid-operation: every register returns to its reset value on the next edge. Any pending ratio is discarded.

## Timing
- Reset values:
  - `clk_out`=0, `clk_en`=0, `div_ack`=0, `busy`=0.
  - `cnt`=0, state STOPPED, active ratio = `DEFAULT_DIV`.
- Start latency: `en` is sampled high at edge k, and `clk_out`=1 and `clk_en`=1 from edge k+1.
- Steady state: `clk_en` pulses exactly every N cycles. `clk_out` is high for ceil(N/2) cycles and low for floor(N/2) cycles.
- Stop latency:
  - The last `clk_out` high phase is the one in progress.
  - The state is STOPPED in the cycle after the boundary cycle.
  - No `clk_en` is issued after the stop.
- `div_ack` latency:
  - 1 cycle after `div_load` when stopped.
  - Otherwise it falls in the first cycle after the next boundary that is strictly later than the load cycle.
- `busy` rises in the cycle after `div_load` and falls in the same cycle that `div_ack`=1.

## Structure
- Shared package `clk_div_pkg` holds:
  - the state enum (STOPPED, RUNNING, STOPPING);
  - the constant `DIV_MIN`=2;
  - a clamp function for ratio values.
- One natural sub-module, `clk_div_counter`: the period counter with its boundary and high-phase decode.
- The top level holds the FSM, the shadow/pending logic and the output registers.

## Test plan
- Reset, then `en`=1 with `DEFAULT_DIV`=6 → `clk_out` repeats 3 high / 3 low, `clk_en` every 6 cycles, first `clk_en` one cycle after `en`.
- Running at N=6, `div_load` with `div_val`=5 at `cnt`=2 → `busy`=1 until the boundary. The next period shows `div_ack`=1 and `clk_en`=1 together, then repeats 3 high / 2 low.
- `div_load` 9 then `div_load` 4 before the boundary → a single `div_ack`, and the new period is 4 cycles (2/2).
- `div_val`=0 and `div_val`=1 → both run as N=2 (1 high / 1 low).
- `en` dropped at `cnt`=1 of N=6 → the period completes (high through `cnt`=2, low through `cnt`=5), then `clk_out` stays 0 with no further `clk_en`. `en` re-raised at `cnt`=4 → running continues without a gap.
- `reset`=0 at `cnt`=3 with a ratio pending → the next cycle has all outputs 0, `busy`=0, and the active ratio is back to 6.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the divider FSM state encoding, the minimum legal ratio and the ratio clamp.
// No ports; imported by the interface, the counter and the top level.
package clk_div_pkg;

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Smallest ratio that still yields one high and one low cycle per period.
    localparam int DIV_MIN = 2;

    // Ratios of 0 and 1 have no meaningful waveform, so they are silently
    // promoted to the minimum instead of being flagged.
    function automatic int clamp_div(input int value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle between a divider client and clk_divider_prog.
// Ports: en, div_val, div_load (client -> divider); div_ack, clk_out, clk_en, busy (divider -> client).
// No flow control: div_load is a one-cycle strobe, div_ack a one-cycle completion pulse.
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             div_ack;
    logic             clk_out;
    logic             clk_en;
    logic             busy;

    modport master (
        output en, div_val, div_load,
        input  div_ack, clk_out, clk_en, busy
    );

    modport slave (
        input  en, div_val, div_load,
        output div_ack, clk_out, clk_en, busy
    );
endinterface

// File: rtl/clk_div_counter.sv
// Period counter for the divider: counts 0..N-1, flags the boundary cycle and decodes the high phase.
// Ports: clk/reset; start, run, div_cur, div_next in; boundary, high_next out. cnt updates every cycle.
// No backpressure: start forces cnt to 0 in a running period, !run parks cnt at 0.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,      // next cycle is the first cycle of a period
    input  logic             run,        // next cycle is inside a period
    input  logic [DIV_W-1:0] div_cur,    // ratio of the period in progress
    input  logic [DIV_W-1:0] div_next,   // ratio that will be active next cycle
    output logic             boundary,   // current cycle is cnt == N-1
    output logic             high_next   // clk_out value for next cycle
);
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] high_len;

    always_comb begin
        cnt_d = '0;
        if (run && !start) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ceil(N/2): odd ratios spend the extra cycle in the high phase.
    assign high_len  = (div_next >> 1) + {{(DIV_W-1){1'b0}}, div_next[0]};
    assign high_next = run && (cnt_d < high_len);

    // div_cur is never below 2, so the subtraction cannot wrap; while stopped
    // cnt sits at 0 and the compare stays false on its own.
    assign boundary = (cnt_q == (div_cur - 1'b1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider producing clk_out and a period-start clk_en pulse.
// Ports: clk, reset (sync, active-low), bus (slave). Start latency 1 cycle; ratio/stop changes land on period boundaries.
// No backpressure: a div_load while a ratio is pending overwrites the shadow; only the last one is acked.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic     clk,
    input  logic     reset,
    clk_div_if.slave bus
);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(clamp_div(DEFAULT_DIV));

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic             clk_out_q;
    logic             clk_en_q;
    logic             start_d;
    logic             run_d;
    logic             boundary;
    logic             high_next;
    logic [DIV_W-1:0] load_val;

    assign load_val = DIV_W'(clamp_div(int'(bus.div_val)));

    clk_div_counter #(.DIV_W(DIV_W)) u_counter (
        .clk       (clk),
        .reset     (reset),
        .start     (start_d),
        .run       (run_d),
        .div_cur   (div_q),
        .div_next  (div_d),
        .boundary  (boundary),
        .high_next (high_next)
    );

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        start_d   = 1'b0;

        unique case (state_q)
            STOPPED: begin
                if (bus.en) begin
                    state_d = RUNNING;
                    start_d = 1'b1;
                end
            end
            RUNNING, STOPPING: begin
                // A period in progress always runs to its boundary; en is only
                // acted on there, which is what keeps clk_out free of runts.
                if (boundary) begin
                    if (bus.en) begin
                        state_d = RUNNING;
                        start_d = 1'b1;
                    end else begin
                        state_d = STOPPED;
                    end
                end else begin
                    state_d = bus.en ? RUNNING : STOPPING;
                end
            end
            default: state_d = STOPPED;
        endcase

        if (state_q == STOPPED) begin
            // Nothing to protect while stopped: take the ratio right away.
            if (bus.div_load) begin
                div_d     = load_val;
                ack_d     = 1'b1;
                pending_d = 1'b0;
            end else if (pending_q) begin
                div_d     = shadow_q;
                ack_d     = 1'b1;
                pending_d = 1'b0;
            end
        end else begin
            if (boundary && pending_q) begin
                div_d     = shadow_q;
                ack_d     = 1'b1;
                pending_d = 1'b0;
            end
            // A load in the boundary cycle itself is applied after pending_q
            // was consumed above, so it waits for the following boundary.
            if (bus.div_load) begin
                shadow_d  = load_val;
                pending_d = 1'b1;
            end
        end
    end

    assign run_d = (state_d != STOPPED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= STOPPED;
            div_q     <= DIV_RESET;
            shadow_q  <= DIV_RESET;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            clk_out_q <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            clk_out_q <= high_next;
            clk_en_q  <= start_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.clk_en  = clk_en_q;
    assign bus.div_ack = ack_q;
    assign bus.busy    = pending_q;

endmodule
